sram_read_sampler: RTL and testbench
====================================

// Module: sram_read_sampler
// PURPOSE
//   Parametrised SRAM bus read-cycle detector and sampler for the sampling front end.
//   Synchronises CE#/OE#/WE#, address and data from the target SRAM bus.
//   Qualifies a read once CE#=0, OE#=0, WE#=1 have held for a programmable settle time.
//   Then captures {addr,data} into a one-entry valid/ready output buffer.
//   Also counts reads, flags short (aborted) cycles and flags dropped samples.
// PARAMETERS
//   ADDR_W       16  SRAM address width
//   DATA_W       8   SRAM data width
//   CNT_W        4   settle counter width; cfg_settle range 0..2^CNT_W-1
//   SYNC_STAGES  2   input synchroniser depth (>=2); same delay on all inputs
//   TOTAL_W      16  width of read_total counter
// PORTS
//   clk          in   1        sampling clock
//   rst_n        in   1        synchronous reset, active low
//   ce_n         in   1        SRAM chip enable pin (active low, async)
//   oe_n         in   1        SRAM output enable pin (active low, async)
//   we_n         in   1        SRAM write enable pin (active low, async)
//   addr         in   ADDR_W   SRAM address pins (async)
//   data         in   DATA_W   SRAM data pins (async)
//   cfg_settle   in   CNT_W    consecutive active cycles to qualify a read (0 treated as 1)
//   ovr_clr      in   1        clears sample_ovr
//   read         out  1        level: qualified read in progress
//   short_cyc    out  1        1-cycle pulse: active cycle ended before qualifying
//   sample_valid out  1        output buffer holds a sample
//   sample_ready in   1        consumer accepts sample when valid&ready
//   sample_addr  out  ADDR_W   captured address
//   sample_data  out  DATA_W   captured data
//   sample_ovr   out  1        sticky: a capture was dropped (buffer full)
//   read_total   out  TOTAL_W  qualified reads since reset, wraps modulo 2^TOTAL_W
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): sync ctrl flops=1, addr/data flops=0, state=IDLE, cnt=0,
//     read=0, short_cyc=0, sample_valid=0, sample_addr=0, sample_data=0, sample_ovr=0,
//     read_total=0. Reset mid-read aborts; no short_cyc and no capture is generated.
//   Sync: all inputs pass through SYNC_STAGES flops; act = ~ce_s & ~oe_s & we_s.
//   Compare addr_s with prev_addr, registered every cycle.
//   N = (cfg_settle==0) ? 1 : cfg_settle, sampled every cycle; changing it mid-count
//     takes effect immediately.
//   FSM states IDLE, COUNT, READ (all registered outputs):
//   - IDLE: act=1 -> if N==1 go READ and capture, else COUNT with cnt=1.
//   - COUNT: act=1 and addr_s==prev_addr -> cnt++; go READ when cnt+1==N, capture that edge.
//   - COUNT: act=1 and addr changed -> stay COUNT, cnt=1 (restart, no short_cyc).
//   - COUNT: act=0 -> IDLE, cnt=0, short_cyc=1 for one cycle.
//   - READ: read=1. act=0 -> IDLE, read=0 next cycle.
//   - READ: act=1 and addr changed (page-mode access) -> COUNT, cnt=1, read=0.
//   - read=1 exactly while state==READ.
//   Latency: pin-active to read=1 is SYNC_STAGES+N clk cycles.
//   cnt saturates at 2^CNT_W-1 and never wraps.
//   Capture: on entry to READ, latch {addr_s,data_s} and read_total++ (wraps).
//   Capture vs buffer (one edge):
//   - valid=0 or (valid&ready): load sample, valid=1.
//   - valid=1 and ready=0: keep old sample, set sample_ovr, still count read_total.
//   - valid&ready with no capture: valid=0.
//   sample_addr/sample_data are stable while valid=1 and ready=0.
//   sample_ovr clears on ovr_clr=1 unless a drop occurs the same edge (set wins).
// TESTING
//   1 cfg_settle=14; hold ce_n=oe_n=0, we_n=1, addr=0x1234, data=0xA5 for 20 cycles, ready=1
//     -> read rises 16 cycles after pins; one sample {0x1234,0xA5}; read_total=1.
//   2 cfg_settle=14; active for 10 cycles then ce_n=1 -> short_cyc single pulse; read never 1;
//     no sample.
//   3 ready=0; two qualified reads -> first sample held unchanged; sample_ovr=1; read_total=2;
//     ovr_clr=1 -> sample_ovr=0.
//   4 cfg_settle=3; during READ change addr 0x0010->0x0011 with pins active -> read drops one
//     cycle after; read re-qualifies 3 cycles later; second sample addr=0x0011.
//   5 cfg_settle=0 -> qualifies as N=1 (read after SYNC_STAGES+1).
//   6 rst_n=0 mid-COUNT -> all outputs reset values next edge; no short_cyc.
//   7 TOTAL_W=4; 17 reads -> read_total=1 (wrap).

Source files
------------

// File: rtl/sram_read_sampler.sv
`default_nettype none
// ============================================================================
// Module      : sram_read_sampler
// Description : Synchronises an asynchronous SRAM bus, qualifies read cycles
//               after a programmable settle time and buffers {addr,data}.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_read_sampler #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce_n,
    input  logic               oe_n,
    input  logic               we_n,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  data,
    input  logic [CNT_W-1:0]   cfg_settle,
    input  logic               ovr_clr,
    output logic               read,
    output logic               short_cyc,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [ADDR_W-1:0]  sample_addr,
    output logic [DATA_W-1:0]  sample_data,
    output logic               sample_ovr,
    output logic [TOTAL_W-1:0] read_total
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]   c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W:0]     c_inc_one   = (CNT_W + 1)'(1);
    localparam logic [TOTAL_W-1:0] c_total_one = TOTAL_W'(1);

    // Synchroniser chains: index 0 is first stage, top index feeds the logic
    logic [SYNC_STAGES-1:0][2:0]        r_ctrl_sync;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_addr_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_sync;
    logic [ADDR_W-1:0]                  r_prev_addr;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_read;
    logic               r_short;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_sample_addr;
    logic [DATA_W-1:0]  r_sample_data;
    logic               r_ovr;
    logic [TOTAL_W-1:0] r_total;

    logic               w_act;
    logic [ADDR_W-1:0]  w_addr_s;
    logic [DATA_W-1:0]  w_data_s;
    logic               w_addr_chg;
    logic [CNT_W-1:0]   w_settle;
    logic [CNT_W:0]     w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_qualify;
    logic               w_cap;
    logic               w_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_sync <= '1;
            r_addr_sync <= '0;
            r_data_sync <= '0;
            r_prev_addr <= '0;
        end else begin
            r_ctrl_sync <= {r_ctrl_sync[SYNC_STAGES-2:0], {ce_n, oe_n, we_n}};
            r_addr_sync <= {r_addr_sync[SYNC_STAGES-2:0], addr};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data};
            r_prev_addr <= w_addr_s;
        end
    end

    assign w_act      = ~r_ctrl_sync[SYNC_STAGES-1][2] & ~r_ctrl_sync[SYNC_STAGES-1][1]
                      &  r_ctrl_sync[SYNC_STAGES-1][0];
    assign w_addr_s   = r_addr_sync[SYNC_STAGES-1];
    assign w_data_s   = r_data_sync[SYNC_STAGES-1];
    assign w_addr_chg = (w_addr_s != r_prev_addr);

    assign w_settle   = (cfg_settle == c_cnt_zero) ? c_cnt_one : cfg_settle;
    assign w_cnt_inc  = {1'b0, r_cnt} + c_inc_one;
    assign w_cnt_next = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
    // >= rather than == so a settle value lowered mid-count still qualifies
    assign w_qualify  = (w_cnt_inc >= {1'b0, w_settle});

    assign w_cap  = w_act & (((r_state == ST_IDLE) & (w_settle == c_cnt_one)) |
                             ((r_state == ST_COUNT) & ~w_addr_chg & w_qualify));
    assign w_drop = w_cap & r_valid & ~sample_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= c_cnt_zero;
            r_read  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            r_short <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_act) begin
                        r_cnt <= c_cnt_one;
                        if (w_cap) begin
                            r_state <= ST_READ;
                            r_read  <= 1'b1;
                        end else begin
                            r_state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= c_cnt_zero;
                        r_short <= 1'b1;
                    end else if (w_addr_chg) begin
                        r_cnt <= c_cnt_one;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cap) begin
                            r_state <= ST_READ;
                            r_read  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= c_cnt_zero;
                        r_read  <= 1'b0;
                    end else if (w_addr_chg) begin
                        // Page-mode access: new address must settle again
                        r_state <= ST_COUNT;
                        r_cnt   <= c_cnt_one;
                        r_read  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= c_cnt_zero;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_sample_addr <= '0;
            r_sample_data <= '0;
            r_ovr         <= 1'b0;
            r_total       <= '0;
        end else begin
            if (w_cap) begin
                r_total <= r_total + c_total_one;
                if (!r_valid || sample_ready) begin
                    r_valid       <= 1'b1;
                    r_sample_addr <= w_addr_s;
                    r_sample_data <= w_data_s;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign read         = r_read;
    assign short_cyc    = r_short;
    assign sample_valid = r_valid;
    assign sample_addr  = r_sample_addr;
    assign sample_data  = r_sample_data;
    assign sample_ovr   = r_ovr;
    assign read_total   = r_total;

endmodule
`default_nettype wire

// File: tb/tb_sram_read_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_read_sampler
// Description : Directed table-driven bench for sram_read_sampler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_read_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_n, oe_n, we_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  cfg_settle;
    logic        ovr_clr;
    logic        read, short_cyc, sample_valid, sample_ready, sample_ovr;
    logic [15:0] sample_addr;
    logic [7:0]  sample_data;
    logic [3:0]  read_total;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_read_sampler #(
        .ADDR_W(16), .DATA_W(8), .CNT_W(4), .SYNC_STAGES(2), .TOTAL_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n),
        .addr(addr), .data(data), .cfg_settle(cfg_settle), .ovr_clr(ovr_clr),
        .read(read), .short_cyc(short_cyc), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_addr(sample_addr),
        .sample_data(sample_data), .sample_ovr(sample_ovr), .read_total(read_total)
    );

    typedef struct {
        logic [3:0]  settle;
        logic [15:0] a;
        logic [7:0]  d;
        int          hold;
        int          exp_rise;
        int          exp_high;
        int          exp_short;
        int          exp_samples;
        logic [3:0]  exp_total;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pins_idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic pins_read(input logic [15:0] a, input logic [7:0] d);
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a; data = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pins_idle(); addr = '0; data = '0;
        ovr_clr = 1'b0; sample_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_read(input logic [15:0] a, input logic [7:0] d,
                              input int hold, input int gap);
        pins_read(a, d);
        repeat (hold) tick();
        pins_idle();
        repeat (gap) tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int rise, high, shorts, samples;
        logic [15:0] la;
        logic [7:0]  ld;
        rise = 0; high = 0; shorts = 0; samples = 0; la = '0; ld = '0;
        do_reset();
        cfg_settle = v.settle;
        pins_read(v.a, v.d);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (read) begin
                high++;
                if (rise == 0) rise = k;
            end
            if (short_cyc) shorts++;
            if (sample_valid) begin
                samples++;
                la = sample_addr;
                ld = sample_data;
            end
            if (k == v.hold) pins_idle();
        end
        check($sformatf("v%0d_rise", idx), 32'(rise), 32'(v.exp_rise));
        check($sformatf("v%0d_high", idx), 32'(high), 32'(v.exp_high));
        check($sformatf("v%0d_short", idx), 32'(shorts), 32'(v.exp_short));
        check($sformatf("v%0d_samples", idx), 32'(samples), 32'(v.exp_samples));
        check($sformatf("v%0d_total", idx), 32'(read_total), 32'(v.exp_total));
        check($sformatf("v%0d_ovr", idx), 32'(sample_ovr), 32'(0));
        if (v.exp_samples > 0) begin
            check($sformatf("v%0d_saddr", idx), 32'(la), 32'(v.a));
            check($sformatf("v%0d_sdata", idx), 32'(ld), 32'(v.d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rcnt, shorts, r;
        logic [4:0] exp_rd [5];
        //            settle a        d      hold rise high short samp total
        vt[0] = '{4'd14, 16'h1234, 8'hA5, 20, 16, 7, 0, 1, 4'd1};
        vt[1] = '{4'd14, 16'h1234, 8'hA5, 10,  0, 0, 1, 0, 4'd0};
        vt[2] = '{4'd0,  16'h0042, 8'h5A,  5,  3, 5, 0, 1, 4'd1};
        vt[3] = '{4'd1,  16'hBEEF, 8'h01,  3,  3, 3, 0, 1, 4'd1};
        vt[4] = '{4'd2,  16'h8001, 8'hFF,  2,  4, 1, 0, 1, 4'd1};
        vt[5] = '{4'd3,  16'h7777, 8'h3C,  2,  0, 0, 1, 0, 4'd0};
        vt[6] = '{4'd15, 16'hFFFF, 8'h80, 15, 17, 1, 0, 1, 4'd1};

        cfg_settle = 4'd2;
        do_reset();
        check("rst_read", 32'(read), 32'(0));
        check("rst_short", 32'(short_cyc), 32'(0));
        check("rst_valid", 32'(sample_valid), 32'(0));
        check("rst_ovr", 32'(sample_ovr), 32'(0));
        check("rst_total", 32'(read_total), 32'(0));
        check("rst_saddr", 32'(sample_addr), 32'(0));

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // Back-pressure: second capture is dropped, first sample held
        do_reset();
        cfg_settle = 4'd2;
        sample_ready = 1'b0;
        pulse_read(16'h0100, 8'h11, 4, 4);
        check("bp_valid1", 32'(sample_valid), 32'(1));
        check("bp_addr1", 32'(sample_addr), 32'h0100);
        check("bp_ovr1", 32'(sample_ovr), 32'(0));
        pulse_read(16'h0200, 8'h22, 4, 4);
        check("bp_addr2", 32'(sample_addr), 32'h0100);
        check("bp_data2", 32'(sample_data), 32'h11);
        check("bp_ovr2", 32'(sample_ovr), 32'(1));
        check("bp_total", 32'(read_total), 32'(2));
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        check("bp_ovr_clr", 32'(sample_ovr), 32'(0));
        check("bp_valid_hold", 32'(sample_valid), 32'(1));
        sample_ready = 1'b1; tick();
        check("bp_valid_drain", 32'(sample_valid), 32'(0));

        // Page-mode address change during READ
        do_reset();
        cfg_settle = 4'd3;
        pins_read(16'h0010, 8'h33);
        r = 0;
        for (int k = 0; k < 20 && r == 0; k++) begin
            tick();
            if (read) r = 1;
        end
        check("pg_first_read", 32'(r), 32'(1));
        addr = 16'h0011; data = 8'h44;
        exp_rd = '{5'd1, 5'd1, 5'd0, 5'd0, 5'd1};
        shorts = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (short_cyc) shorts++;
            check($sformatf("pg_read_off%0d", k + 1), 32'(read), 32'(exp_rd[k]));
        end
        check("pg_valid", 32'(sample_valid), 32'(1));
        check("pg_saddr", 32'(sample_addr), 32'h0011);
        check("pg_sdata", 32'(sample_data), 32'h44);
        check("pg_total", 32'(read_total), 32'(2));
        check("pg_short", 32'(shorts), 32'(0));
        pins_idle();
        repeat (4) tick();

        // Reset in the middle of a count after a held sample
        do_reset();
        cfg_settle = 4'd2;
        sample_ready = 1'b0;
        pulse_read(16'h0ABC, 8'h77, 4, 4);
        cfg_settle = 4'd10;
        pins_read(16'h0DEF, 8'h99);
        repeat (6) tick();
        rst_n = 1'b0; pins_idle(); tick(); rst_n = 1'b1;
        check("mr_read", 32'(read), 32'(0));
        check("mr_short", 32'(short_cyc), 32'(0));
        check("mr_valid", 32'(sample_valid), 32'(0));
        check("mr_saddr", 32'(sample_addr), 32'(0));
        check("mr_sdata", 32'(sample_data), 32'(0));
        check("mr_total", 32'(read_total), 32'(0));
        rcnt = 0; shorts = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (read) rcnt++;
            if (short_cyc) shorts++;
        end
        check("mr_no_short", 32'(shorts), 32'(0));
        check("mr_no_read", 32'(rcnt), 32'(0));
        sample_ready = 1'b1;

        // read_total wraps modulo 16
        do_reset();
        cfg_settle = 4'd1;
        for (int i = 0; i < 17; i++) begin
            pulse_read(16'(i), 8'(i), 2, 4);
            if (i == 14) check("wrap_total15", 32'(read_total), 32'(15));
        end
        check("wrap_total17", 32'(read_total), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
